leaf_out_packetizer: RTL

Parametrised user-to-BFT egress stage for a leaf. It takes NUM_OUT_PORTS valid/ack user streams and arbitrates them round-robin. Each granted word becomes one BFT packet carrying a per-port destination (leaf, port), a per-port wrapping BRAM address and the payload. Per-port credits, a runtime destination table and resend-safe packet holding are added, so a leaf with any out-port count reuses one block instead of a fixed iNoM shell.

---
 rtl/leaf_out_packetizer_pkg.sv | 56 +++++
 rtl/leaf_out_packetizer_rr_arbiter.sv | 48 ++++
 rtl/leaf_out_packetizer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/leaf_out_packetizer_pkg.sv
// Shared definitions for the leaf egress packetizer.
// Packet layout, MSB to LSB: {valid, dest_leaf, dest_port, addr, payload}.
// Field offsets come from a layout function, so every parameterisation
// shares the same packing code. The *_BIT/*_LSB constants give the offsets
// for the default configuration (5/4/7/32, 49-bit packet).
package leaf_out_packetizer_pkg;

  localparam int MAX_PACKET_BITS = 128;
  typedef logic [MAX_PACKET_BITS-1:0] wide_packet_t;

  typedef struct packed {
    int valid_bit;
    int leaf_lsb;
    int port_lsb;
    int addr_lsb;
  } packet_layout_t;

  function automatic packet_layout_t packet_layout(input int leaf_bits, input int port_bits,
                                                   input int addr_bits, input int payload_bits);
    packet_layout_t l;
    l.addr_lsb  = payload_bits;
    l.port_lsb  = payload_bits + addr_bits;
    l.leaf_lsb  = l.port_lsb + port_bits;
    l.valid_bit = l.leaf_lsb + leaf_bits;
    return l;
  endfunction

  localparam packet_layout_t DEFAULT_LAYOUT = packet_layout(5, 4, 7, 32);
  localparam int VALID_BIT = DEFAULT_LAYOUT.valid_bit;
  localparam int LEAF_LSB  = DEFAULT_LAYOUT.leaf_lsb;
  localparam int PORT_LSB  = DEFAULT_LAYOUT.port_lsb;
  localparam int ADDR_LSB  = DEFAULT_LAYOUT.addr_lsb;

  // One extra bit so the counter can hold the full buffer depth.
  function automatic int credit_bits(input int bram_addr_bits);
    return bram_addr_bits + 1;
  endfunction

  function automatic bit packet_bits_ok(input int packet_bits, input int leaf_bits,
                                        input int port_bits, input int addr_bits,
                                        input int payload_bits);
    return packet_bits == 1 + leaf_bits + port_bits + addr_bits + payload_bits;
  endfunction

  // Field values must already be zero-extended to 64 bits.
  function automatic wide_packet_t make_packet(input packet_layout_t l,
                                               input logic [63:0] leaf, input logic [63:0] port,
                                               input logic [63:0] addr, input logic [63:0] payload);
    return (wide_packet_t'(1)       << l.valid_bit) |
           (wide_packet_t'(leaf)    << l.leaf_lsb)  |
           (wide_packet_t'(port)    << l.port_lsb)  |
           (wide_packet_t'(addr)    << l.addr_lsb)  |
            wide_packet_t'(payload);
  endfunction

endpackage

// File: rtl/leaf_out_packetizer_rr_arbiter.sv
// Round-robin arbiter. Grants the first requester at or after the pointer,
// wrapping, and moves the pointer to one past the winner.
// Ports: clk, reset (async active-low), en (grant allowed this cycle),
//        req (requests), grant (one-hot or zero), grant_idx, grant_any.
module rr_arbiter #(
  parameter  int NUM_REQ = 7,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default before the search loop, otherwise
    // the paths that skip an assignment would infer latches.
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (en && !grant_any && req[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant_any) grant = NUM_REQ'(1) << grant_idx;
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      ptr <= '0;
    end else if (grant_any) begin
      ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/leaf_out_packetizer.sv
// Leaf user-to-BFT egress stage. Arbitrates NUM_OUT_PORTS valid/ack user
// streams round-robin; each granted word becomes one packet
// {1, dest_leaf, dest_port, addr, payload} presented on the next cycle.
// Ports:
//   clk, reset (async active-low)
//   din_leaf_user2interface  user payloads, port i at slice i
//   vld_user2interface       per-port valid
//   ack_interface2user       per-port ack (combinational, one-hot or zero)
//   cfg_we/cfg_port/cfg_dest destination table write; also enables the port
//   credit_vld/credit_port   credit return (+FREESPACE_UPDATE_SIZE, saturating)
//   resend                   freezes the held packet and blocks new grants
//   dout_leaf_interface2bft  packet, MSB = valid, all-zero when idle
module leaf_out_packetizer
  import leaf_out_packetizer_pkg::*;
#(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_OUT_PORTS         = 7,
  parameter int NUM_BRAM_ADDR_BITS    = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
  input  logic                                  cfg_we,
  input  logic [NUM_PORT_BITS-1:0]              cfg_port,
  input  logic [NUM_LEAF_BITS+NUM_PORT_BITS-1:0] cfg_dest,
  input  logic                                  credit_vld,
  input  logic [NUM_PORT_BITS-1:0]              credit_port,
  input  logic                                  resend,
  output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft
);

  localparam int PTR_W      = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam int CREDIT_W   = credit_bits(NUM_BRAM_ADDR_BITS);
  localparam int CREDIT_MAX = 2 ** NUM_BRAM_ADDR_BITS;
  localparam int DEST_W     = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam packet_layout_t LAYOUT =
    packet_layout(NUM_LEAF_BITS, NUM_PORT_BITS, NUM_ADDR_BITS, PAYLOAD_BITS);

  if (!packet_bits_ok(PACKET_BITS, NUM_LEAF_BITS, NUM_PORT_BITS, NUM_ADDR_BITS, PAYLOAD_BITS))
  begin : g_bad_packet_bits
    $error("PACKET_BITS does not match the sum of the packet fields");
  end

  logic [NUM_OUT_PORTS-1:0] enable, eligible, grant;
  logic [CREDIT_W-1:0]      credit     [NUM_OUT_PORTS];
  logic [CREDIT_W-1:0]      credit_nxt [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr       [NUM_OUT_PORTS];
  logic [DEST_W-1:0]        dest       [NUM_OUT_PORTS];
  logic [PTR_W-1:0]         grant_idx;
  logic                     grant_any;
  logic [PACKET_BITS-1:0]   hold, pkt_next;
  logic [DEST_W-1:0]        dest_sel;
  logic [PAYLOAD_BITS-1:0]  payload_sel;
  int                       credit_sum;

  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      eligible[i] = vld_user2interface[i] & enable[i] & (credit[i] != '0);
    end
  end

  // Grants are blocked while resend holds the output; otherwise the held
  // packet drains this cycle, so a new one can be captured behind it.
  rr_arbiter #(.NUM_REQ(NUM_OUT_PORTS)) u_rr_arbiter (
    .clk       (clk),
    .reset     (reset),
    .en        (~resend),
    .req       (eligible),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign ack_interface2user = grant;

  always_comb begin
    dest_sel    = dest[grant_idx];
    payload_sel = din_leaf_user2interface[int'(grant_idx)*PAYLOAD_BITS +: PAYLOAD_BITS];
    pkt_next    = PACKET_BITS'(make_packet(LAYOUT,
                    64'(dest_sel[DEST_W-1:NUM_PORT_BITS]),
                    64'(dest_sel[NUM_PORT_BITS-1:0]),
                    64'(addr[grant_idx]),
                    64'(payload_sel)));
  end

  // Send and return on the same port net out before saturating.
  always_comb begin
    credit_sum = 0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      credit_sum = int'(credit[i]);
      if (grant[i]) credit_sum = credit_sum - 1;
      if (credit_vld && credit_port == NUM_PORT_BITS'(i))
        credit_sum = credit_sum + FREESPACE_UPDATE_SIZE;
      if (credit_sum > CREDIT_MAX) credit_sum = CREDIT_MAX;
      credit_nxt[i] = CREDIT_W'(credit_sum);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold   <= '0;
      enable <= '0;
      // NOTE: these per-port arrays are a handful of flops, not a RAM, and
      // must start at zero, so resetting them is intended.
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit[i] <= '0;
        addr[i]   <= '0;
        dest[i]   <= '0;
      end
    end else begin
      if (!resend) hold <= grant_any ? pkt_next : '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit[i] <= credit_nxt[i];
        if (grant[i]) addr[i] <= addr[i] + 1'b1;
        // Out-of-range cfg_port never matches, so such writes are dropped.
        if (cfg_we && cfg_port == NUM_PORT_BITS'(i)) begin
          dest[i]   <= cfg_dest;
          enable[i] <= 1'b1;
        end
      end
    end
  end

  assign dout_leaf_interface2bft = resend ? '0 : hold;

endmodule
